axis_lane_swapper: RTL and testbench
====================================

// Module: axis_lane_swapper
//
// PURPOSE
// Parametrised AXI-Stream byte/lane swapper for the io_port datapath. Generalises the 64-bit fixed swapper:
// - any power-of-two byte width
// - swap mode latched per packet, so it cannot change mid-packet
// - one registered output stage plus skid buffer, for full throughput and no combinational tready path
// Sits between a transport port (Ethernet/PCIe/host) and the CHDR crossbar.
//
// PARAMETERS
// WIDTH      64  tdata width in bits; power of two, 16..512
// USER_W     1   tuser width; passed through unmodified
// SWAP_W     log2(WIDTH/8) (derived localparam, not overridable); width of swap_lanes
//
// PORTS
// clk         in   1        clock
// reset       in   1        synchronous, active-high reset
// swap_lanes  in   SWAP_W   requested swap mode; sampled only at packet start
// i_tdata     in   WIDTH    input data
// i_tuser     in   USER_W   input sideband
// i_tlast     in   1        input end of packet
// i_tvalid    in   1        input valid
// i_tready    out  1        input ready
// o_tdata     out  WIDTH    swapped data
// o_tuser     out  USER_W   sideband, delayed with data
// o_tlast     out  1        output end of packet
// o_tvalid    out  1        output valid
// o_tready    in   1        output ready
// o_mode      out  SWAP_W   mode in force for the packet currently on the output
//
// BEHAVIOUR
// - Swap rule: output byte b = input byte (b XOR mode).
//   - Bit k of mode swaps adjacent 2^k-byte groups.
//   - All bits compose in any order.
//   - WIDTH=64 encoding: 3'b100 swaps 32-bit halves, 3'b010 swaps 16-bit lanes, 3'b001 swaps bytes.
// - Mode latch:
//   - sof flag is set by reset and by an accepted beat with i_tlast=1.
//   - On an accepted beat with sof=1, swap_lanes is captured into the mode register and used for that beat.
//   - Later beats of the packet use the held mode.
//   - Changes to swap_lanes mid-packet have no effect.
// - Handshake: a beat transfers when tvalid & tready.
// - Latency: 1 clk from input acceptance to o_tvalid.
// - Throughput: sustained 1 beat/clk while o_tready=1.
// - Skid buffer: one extra entry.
//   - i_tready = ~reset & ~skid_valid, driven only from registers.
//   - o_tready low while the output register is full: the next accepted beat goes to skid; i_tready drops the following cycle.
//   - o_tready returns high: the output register reloads from skid in the same clk.
// - Output stability: o_tdata, o_tuser, o_tlast and o_mode are stable while o_tvalid=1 and o_tready=0.
// - Order: beat order is preserved across the skid path.
// - Simultaneous events: output pop and input push in the same clk with skid empty means the output register loads the new beat directly, with no bubble.
// - Reset values: o_tvalid=0, skid_valid=0, sof=1, mode=0, o_mode=0, i_tready=0 while reset is high.
//   o_tdata/o_tuser/o_tlast are don't-care while o_tvalid=0.
// - Reset mid-packet: in-flight beats are discarded, and the next accepted beat is treated as a start of packet.
// - No tkeep: partial last words are swapped as full words; upstream pads.
//
// STRUCTURE
// - Shared package io_port_pkg:
//   - function swap_w(width) returning log2(width/8)
//   - localparam mode encodings SWAP_NONE, SWAP_8B, SWAP_16B, SWAP_32B
// - Sub-module lane_swap_comb #(WIDTH): pure combinational byte permutation (i_data, mode -> o_data).
//   Instanced once on the input side, so skid and output registers hold already-swapped data.
// - Top level holds the sof/mode registers, the output register and the skid register.
//
// TESTING
// 1. WIDTH=64, mode 3'b001, 1-beat packet 64'h0011223344556677 -> o_tdata 64'h1100332255447766 one clk after acceptance.
// 2. WIDTH=64, mode 3'b111, data 64'h0011223344556677 -> 64'h7766554433221100.
//    Also mode 3'b100 -> 64'h4455667700112233.
// 3. 4-beat packet with mode 3'b010 at beat 0, swap_lanes flipped to 3'b000 at beat 2:
//    -> all 4 beats swapped with 3'b010, o_mode=3'b010; the next packet uses 3'b000.
// 4. Random o_tready (50%) and continuous i_tvalid, 1000 beats:
//    -> no loss, no duplication, order kept, output stable while stalled.
//    With o_tready=1 the steady state reaches 1 beat/clk.
// 5. reset pulsed during beat 2 of a 4-beat packet:
//    -> o_tvalid=0 the next clk; the next accepted beat re-latches swap_lanes.
// 6. WIDTH=256, mode 5'b10000, data bytes 0..31 -> output bytes 16..31 followed by 0..15.

Source files
------------

// File: rtl/io_port_pkg.sv
// Shared definitions for the io_port datapath: swap-mode width helper and
// the named lane-swap mode encodings.
package io_port_pkg;

  // Number of swap-mode bits needed for a tdata width (one bit per byte-group level).
  function automatic int swap_w(input int width);
    return $clog2(width / 8);
  endfunction

  localparam int SWAP_NONE = 0;
  localparam int SWAP_8B   = 1;
  localparam int SWAP_16B  = 2;
  localparam int SWAP_32B  = 4;

endpackage

// File: rtl/lane_swap_comb.sv
// Pure combinational byte permutation: output byte b takes input byte (b ^ mode),
// so each mode bit k swaps neighbouring 2^k-byte groups.
module lane_swap_comb
  import io_port_pkg::*;
#(
  parameter  int WIDTH  = 64,
  localparam int SWAP_W = swap_w(WIDTH)
) (
  input  logic [WIDTH-1:0]  i_data,
  input  logic [SWAP_W-1:0] mode,
  output logic [WIDTH-1:0]  o_data
);

  localparam int NB = WIDTH / 8;

  logic [7:0] in_bytes [NB];

  for (genvar b = 0; b < NB; b++) begin : g_byte
    localparam logic [SWAP_W-1:0] IDX = SWAP_W'(b);
    assign in_bytes[b]      = i_data[8*b +: 8];
    assign o_data[8*b +: 8] = in_bytes[IDX ^ mode];
  end

endmodule

// File: rtl/axis_lane_swapper.sv
// AXI-Stream lane swapper with per-packet mode latch, one registered output
// stage and a one-entry skid buffer so i_tready comes only from registers.
module axis_lane_swapper
  import io_port_pkg::*;
#(
  parameter  int WIDTH  = 64,
  parameter  int USER_W = 1,
  localparam int SWAP_W = swap_w(WIDTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SWAP_W-1:0] swap_lanes,
  input  logic [WIDTH-1:0]  i_tdata,
  input  logic [USER_W-1:0] i_tuser,
  input  logic              i_tlast,
  input  logic              i_tvalid,
  output logic              i_tready,
  output logic [WIDTH-1:0]  o_tdata,
  output logic [USER_W-1:0] o_tuser,
  output logic              o_tlast,
  output logic              o_tvalid,
  input  logic              o_tready,
  output logic [SWAP_W-1:0] o_mode
);

  logic              sof;
  logic [SWAP_W-1:0] mode;
  logic [SWAP_W-1:0] cur_mode;
  logic [WIDTH-1:0]  swapped;
  logic              in_fire;
  logic              out_free;

  logic              skid_valid;
  logic [WIDTH-1:0]  skid_data;
  logic [USER_W-1:0] skid_user;
  logic              skid_last;
  logic [SWAP_W-1:0] skid_mode;

  assign i_tready = ~reset & ~skid_valid;
  assign in_fire  = i_tvalid & i_tready;
  assign out_free = ~o_tvalid | o_tready;
  assign cur_mode = sof ? swap_lanes : mode;

  // Swapping happens before the registers, so skid and output hold final data.
  lane_swap_comb #(
    .WIDTH (WIDTH)
  ) u_swap (
    .i_data (i_tdata),
    .mode   (cur_mode),
    .o_data (swapped)
  );

  // swap_lanes is only honoured on the first accepted beat of a packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      sof  <= 1'b1;
      mode <= '0;
    end else if (in_fire) begin
      sof  <= i_tlast;
      mode <= cur_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_tvalid   <= 1'b0;
      o_mode     <= '0;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        o_tvalid   <= 1'b1;
        o_tdata    <= skid_data;
        o_tuser    <= skid_user;
        o_tlast    <= skid_last;
        o_mode     <= skid_mode;
        skid_valid <= 1'b0;
      end else begin
        o_tvalid <= in_fire;
        if (in_fire) begin
          o_tdata <= swapped;
          o_tuser <= i_tuser;
          o_tlast <= i_tlast;
          o_mode  <= cur_mode;
        end
      end
    end else if (in_fire) begin
      // Output is stalled: park the beat that was already promised by i_tready.
      skid_valid <= 1'b1;
      skid_data  <= swapped;
      skid_user  <= i_tuser;
      skid_last  <= i_tlast;
      skid_mode  <= cur_mode;
    end
  end

endmodule

// File: tb/tb_axis_lane_swapper.sv
// Self-checking bench for axis_lane_swapper: directed swap cases, a random
// backpressure run against a queue-based model, reset mid-packet and a 256-bit instance.
module tb_axis_lane_swapper;
  import io_port_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  swap_lanes = '0;
  logic [63:0] i_tdata = '0;
  logic        i_tuser = 1'b0;
  logic        i_tlast = 1'b0;
  logic        i_tvalid = 1'b0;
  logic        i_tready;
  logic [63:0] o_tdata;
  logic        o_tuser;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready = 1'b1;
  logic [2:0]  o_mode;

  logic [4:0]   w_swap_lanes = '0;
  logic [255:0] w_i_tdata = '0;
  logic         w_i_tuser = 1'b0;
  logic         w_i_tlast = 1'b0;
  logic         w_i_tvalid = 1'b0;
  logic         w_i_tready;
  logic [255:0] w_o_tdata;
  logic         w_o_tuser;
  logic         w_o_tlast;
  logic         w_o_tvalid;
  logic         w_o_tready = 1'b1;
  logic [4:0]   w_o_mode;

  int checks = 0;
  int errors = 0;
  int cycle_cnt = 0;
  int in_count = 0;
  int out_count = 0;

  typedef struct packed {
    logic [63:0] data;
    logic        user;
    logic        last;
    logic [2:0]  mode;
  } beat_t;

  beat_t exp_q[$];
  logic  model_sof = 1'b1;
  logic [2:0] model_mode = '0;
  logic  prev_stall = 1'b0;
  beat_t prev_out;

  axis_lane_swapper #(.WIDTH(64), .USER_W(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .swap_lanes (swap_lanes),
    .i_tdata    (i_tdata),
    .i_tuser    (i_tuser),
    .i_tlast    (i_tlast),
    .i_tvalid   (i_tvalid),
    .i_tready   (i_tready),
    .o_tdata    (o_tdata),
    .o_tuser    (o_tuser),
    .o_tlast    (o_tlast),
    .o_tvalid   (o_tvalid),
    .o_tready   (o_tready),
    .o_mode     (o_mode)
  );

  axis_lane_swapper #(.WIDTH(256), .USER_W(1)) dut_wide (
    .clk        (clk),
    .reset      (reset),
    .swap_lanes (w_swap_lanes),
    .i_tdata    (w_i_tdata),
    .i_tuser    (w_i_tuser),
    .i_tlast    (w_i_tlast),
    .i_tvalid   (w_i_tvalid),
    .i_tready   (w_i_tready),
    .o_tdata    (w_o_tdata),
    .o_tuser    (w_o_tuser),
    .o_tlast    (w_o_tlast),
    .o_tvalid   (w_o_tvalid),
    .o_tready   (w_o_tready),
    .o_mode     (w_o_mode)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Reference swap built as successive group exchanges, one per set mode bit.
  function automatic logic [63:0] swapRef(input logic [63:0] d, input logic [2:0] m);
    logic [7:0]  ob [8];
    logic [7:0]  nb [8];
    logic [63:0] r;
    for (int b = 0; b < 8; b++) ob[b] = d[8*b +: 8];
    for (int k = 0; k < 3; k++) begin
      if (m[k]) begin
        for (int b = 0; b < 8; b++)
          nb[b] = (((b >> k) % 2) == 0) ? ob[b + (1 << k)] : ob[b - (1 << k)];
        for (int b = 0; b < 8; b++) ob[b] = nb[b];
      end
    end
    for (int b = 0; b < 8; b++) r[8*b +: 8] = ob[b];
    return r;
  endfunction

  // Scoreboard: sample both handshakes mid-cycle, pop output transfers before pushing inputs.
  always @(negedge clk) begin
    beat_t e;
    logic [2:0] m;
    if (reset) begin
      exp_q.delete();
      model_sof  = 1'b1;
      model_mode = '0;
      prev_stall = 1'b0;
      checkOutput("rst_i_tready", i_tready, 0);
    end else begin
      if (prev_stall) begin
        checkOutput("stall_valid", o_tvalid, 1);
        checkOutput("stall_data", o_tdata, prev_out.data);
        checkOutput("stall_last", o_tlast, prev_out.last);
        checkOutput("stall_mode", o_mode, prev_out.mode);
      end
      if (o_tvalid && o_tready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("sb_data", o_tdata, e.data);
          checkOutput("sb_user", o_tuser, e.user);
          checkOutput("sb_last", o_tlast, e.last);
          checkOutput("sb_mode", o_mode, e.mode);
          out_count++;
        end
      end
      if (i_tvalid && i_tready) begin
        m = model_sof ? swap_lanes : model_mode;
        model_mode = m;
        model_sof  = i_tlast;
        exp_q.push_back('{data: swapRef(i_tdata, m), user: i_tuser, last: i_tlast, mode: m});
        in_count++;
      end
      prev_stall = o_tvalid && !o_tready;
      prev_out   = '{data: o_tdata, user: o_tuser, last: o_tlast, mode: o_mode};
    end
  end

  // Presents one beat and returns one cycle after it was accepted (bounded wait).
  task automatic applyStimulus(input logic [63:0] data, input logic last, input logic [2:0] lanes, input logic user);
    logic hs;
    bit   done;
    i_tdata    = data;
    i_tlast    = last;
    i_tuser    = user;
    swap_lanes = lanes;
    i_tvalid   = 1'b1;
    done       = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      hs = i_tready;
      @(posedge clk);
      #1;
      if (hs) done = 1'b1;
    end
    if (!done) checkOutput("accept_timeout", 0, 1);
  endtask

  localparam logic [63:0] PAT = 64'h0011223344556677;

  initial begin
    logic [255:0] wide_in;
    logic [255:0] wide_exp;
    bit rnd_done;
    bit wdone;
    int start;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_o_tvalid", o_tvalid, 0);
    checkOutput("rst_o_mode", o_mode, 0);
    checkOutput("rst_wide_o_tvalid", w_o_tvalid, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_i_tready", i_tready, 1);
    @(posedge clk);
    #1;

    $display("[TB] directed swap modes");
    applyStimulus(PAT, 1'b1, 3'(SWAP_8B), 1'b0);
    checkOutput("t1_valid", o_tvalid, 1);
    checkOutput("t1_data", o_tdata, 64'h1100332255447766);
    checkOutput("t1_mode", o_mode, 3'b001);
    applyStimulus(PAT, 1'b1, 3'b111, 1'b1);
    checkOutput("t2_rev_data", o_tdata, 64'h7766554433221100);
    checkOutput("t2_rev_user", o_tuser, 1);
    applyStimulus(PAT, 1'b1, 3'(SWAP_32B), 1'b0);
    checkOutput("t2_half_data", o_tdata, 64'h4455667700112233);

    $display("[TB] mode held across packet");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(PAT, i == 3, (i < 2) ? 3'(SWAP_16B) : 3'(SWAP_NONE), 1'b0);
      checkOutput("t3_data", o_tdata, 64'h2233001166774455);
      checkOutput("t3_mode", o_mode, 3'b010);
    end
    applyStimulus(PAT, 1'b1, 3'(SWAP_NONE), 1'b0);
    checkOutput("t3_next_data", o_tdata, PAT);
    checkOutput("t3_next_mode", o_mode, 3'b000);
    i_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] random backpressure run");
    in_count  = 0;
    out_count = 0;
    rnd_done  = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++)
          applyStimulus({$urandom, $urandom}, $urandom_range(0, 3) == 0,
                        3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        i_tvalid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          o_tready = 1'($urandom_range(0, 1));
        end
      end
    join
    o_tready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("t4_in_count", in_count, 1000);
    checkOutput("t4_out_count", out_count, 1000);
    checkOutput("t4_queue_empty", exp_q.size(), 0);

    start = cycle_cnt;
    for (int i = 0; i < 20; i++)
      applyStimulus({$urandom, $urandom}, i == 19, 3'($urandom_range(0, 7)), 1'b0);
    checkOutput("t4_throughput_cycles", cycle_cnt - start, 20);
    i_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] reset mid-packet");
    applyStimulus(PAT, 1'b0, 3'b011, 1'b0);
    o_tready = 1'b0;
    applyStimulus(PAT, 1'b0, 3'b011, 1'b0);
    i_tvalid = 1'b0;
    checkOutput("t5_skid_full_i_tready", i_tready, 0);
    swap_lanes = 3'b001;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t5_o_tvalid_after_rst", o_tvalid, 0);
    checkOutput("t5_o_mode_after_rst", o_mode, 0);
    reset = 1'b0;
    o_tready = 1'b1;
    applyStimulus(PAT, 1'b1, 3'b001, 1'b0);
    checkOutput("t5_relatch_mode", o_mode, 3'b001);
    checkOutput("t5_relatch_data", o_tdata, 64'h1100332255447766);
    i_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] 256-bit instance");
    for (int b = 0; b < 32; b++) begin
      wide_in[8*b +: 8]  = 8'(b);
      wide_exp[8*b +: 8] = (b < 16) ? 8'(b + 16) : 8'(b - 16);
    end
    w_i_tdata    = wide_in;
    w_swap_lanes = 5'b10000;
    w_i_tlast    = 1'b1;
    w_i_tvalid   = 1'b1;
    wdone        = 1'b0;
    for (int n = 0; n < 100 && !wdone; n++) begin
      @(negedge clk);
      wdone = w_i_tready;
      @(posedge clk);
      #1;
    end
    if (!wdone) checkOutput("t6_accept_timeout", 0, 1);
    w_i_tvalid = 1'b0;
    checkOutput("t6_valid", w_o_tvalid, 1);
    checkOutput("t6_data", w_o_tdata, wide_exp);
    checkOutput("t6_mode", w_o_mode, 5'b10000);
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
